dsp_op_controller: RTL and testbench
====================================

// Module: dsp_op_controller
// PURPOSE
//  Sequences the multi-cycle DSP unit driven by the CPU pipeline's start_dsp/op_dsp outputs.
//  Latches operands, runs an iterative multiplier, keeps the accumulator and returns a result.
//  Stalls the pipeline while an operation is in flight. Sits beside the EX stage of CPU_pipeline.
// PARAMETERS
//  XLEN        32    operand/result/accumulator width
//  MUL_CYCLES  XLEN  RUN cycles per multiply (one multiplier bit per cycle); must be >= 1
// PORTS
//  clk         in   1     clock, all state on rising edge
//  reset       in   1     asynchronous, active-low reset (reset==0 clears all state immediately)
//  start_dsp   in   1     DSP request from EX stage, held high while the instruction is stalled
//  op_dsp      in   2     00 MUL, 01 MAC, 10 CLR, 11 READ
//  op_a        in   XLEN  operand A (rs1 value)
//  op_b        in   XLEN  operand B (rs2 value)
//  stall       out  1     freezes the pipeline while a MUL/MAC is pending
//  busy        out  1     high whenever state != IDLE
//  dsp_result  out  XLEN  result of the last completed operation (registered)
//  dsp_valid   out  1     one-cycle pulse: dsp_result updated this cycle
// BEHAVIOUR
//  Reset: state=IDLE; acc, dsp_result, counter, latched operands = 0; dsp_valid=0, busy=0, stall=0.
//  FSM: IDLE -> RUN -> DONE -> IDLE. start_dsp is sampled only in IDLE and ignored in RUN/DONE,
//  so a request held high through its own stall never issues twice. No queueing.
//  IDLE, start & CLR : edge -> acc=0, dsp_result=0, dsp_valid=1 next cycle; stays IDLE; no stall.
//  IDLE, start & READ: edge -> dsp_result=acc, dsp_valid=1 next cycle; stays IDLE; no stall.
//  IDLE, start & MUL/MAC: edge latches op, op_a, op_b, counter=0 -> RUN. Later operand changes ignored.
//  RUN: one shift-add iteration per edge, counter++. At the edge with counter==MUL_CYCLES-1 -> DONE.
//   At that same edge: MUL sets dsp_result=product; MAC sets acc=acc+product, dsp_result=new acc.
//  DONE: dsp_valid=1 for exactly this cycle; next edge -> IDLE.
//  stall = (state==RUN) | (state==IDLE & start_dsp & op_dsp in {MUL,MAC}); combinational; low in DONE.
//  Latency: start sampled in cycle 0 -> stall high in cycles 0..MUL_CYCLES ->
//   dsp_valid high in cycle MUL_CYCLES+1.
//  Arithmetic: unsigned; product = low XLEN bits of op_a*op_b; acc wraps modulo 2^XLEN (no saturation).
//  dsp_valid is low in every cycle not listed above. dsp_result holds its value between operations.
//  Reset mid-RUN: the operation is aborted immediately, acc is lost, there is no dsp_valid,
//   and stall drops with the reset.
// STRUCTURE
//  Package dsp_pkg: dsp_op_e {DSP_MUL=2'b00, DSP_MAC=2'b01, DSP_CLR=2'b10, DSP_READ=2'b11},
//   dsp_state_e {IDLE, RUN, DONE}, default XLEN constant.
//  Sub-module dsp_mul_iter: iterative shift-add multiplier with ports load, a, b, step, product.
//   It has no FSM of its own; the controller owns the counter and the FSM.
// TESTING (XLEN=32, MUL_CYCLES=32)
//  1 Reset:
//    reset=0 with random inputs -> stall, busy, dsp_valid = 0 and dsp_result = 0, including asynchronously mid-cycle.
//  2 MUL 7*6, start_dsp held while stalled:
//    stall high for 33 cycles; a single dsp_valid in cycle 33 with dsp_result=42; acc unchanged.
//  3 CLR; MAC 3*4; MAC 5*5; READ:
//    valid results 0, 12, 37, 37; CLR and READ never raise stall; each valid lands 1 cycle after its start.
//  4 Wrap: CLR; MAC 2*1; MAC 0xFFFFFFFF*1:
//    acc=1. MUL 0x10000*0x10000 -> 0. MUL 0xFFFFFFFF*0xFFFFFFFF -> 1.
//  5 MUL 9*9 with op_a/op_b/op_dsp toggled randomly during RUN and start_dsp pulsed in DONE:
//    result 81, exactly one dsp_valid, FSM returns to IDLE.
//  6 Reset at RUN cycle 10 of MAC 4*4 (acc=5):
//    no dsp_valid, acc=0. A following READ -> 0; a following MUL 2*3 -> 6 with normal latency.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared types and constants for the multi-cycle DSP unit beside the EX stage.
package dsp_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        DSP_MUL  = 2'b00,
        DSP_MAC  = 2'b01,
        DSP_CLR  = 2'b10,
        DSP_READ = 2'b11
    } dsp_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsp_state_e;

    function automatic logic is_mul_op(input logic [1:0] op);
        return (op == DSP_MUL) || (op == DSP_MAC);
    endfunction

endpackage

// File: rtl/dsp_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per step; sequencing is owned by the caller.
module dsp_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            step,
    output logic [XLEN-1:0] product
);

    logic [XLEN-1:0] a_sh;
    logic [XLEN-1:0] b_sh;
    logic [XLEN-1:0] part;
    logic [XLEN-1:0] addend;

    // product already includes the current step, so it can be captured on the final step edge
    assign addend  = b_sh[0] ? a_sh : '0;
    assign product = part + addend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sh <= '0;
            b_sh <= '0;
            part <= '0;
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            part <= '0;
        end else if (step) begin
            part <= product;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
        end
    end

endmodule

// File: rtl/dsp_op_controller.sv
// Sequences MUL/MAC/CLR/READ requests from the EX stage, owns the accumulator and stalls the pipeline.
module dsp_op_controller
    import dsp_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int MUL_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_dsp,
    input  logic [1:0]      op_dsp,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] dsp_result,
    output logic            dsp_valid
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    dsp_state_e      state;
    dsp_op_e         op_q;
    logic [CNT_W-1:0] counter;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mul_product;
    logic            load;
    logic            step;

    function automatic logic [XLEN-1:0] add_wrap(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        return x + y;
    endfunction

    // Gated by reset so the pipeline is released the instant reset asserts
    assign load  = reset && (state == IDLE) && start_dsp && is_mul_op(op_dsp);
    assign step  = (state == RUN);
    assign stall = load || (reset && (state == RUN));
    assign busy  = (state != IDLE);

    dsp_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .a       (op_a),
        .b       (op_b),
        .step    (step),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= DSP_MUL;
            counter    <= '0;
            acc        <= '0;
            dsp_result <= '0;
            dsp_valid  <= 1'b0;
        end else begin
            dsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_dsp) begin
                        case (dsp_op_e'(op_dsp))
                            DSP_CLR: begin
                                acc        <= '0;
                                dsp_result <= '0;
                                dsp_valid  <= 1'b1;
                            end
                            DSP_READ: begin
                                dsp_result <= acc;
                                dsp_valid  <= 1'b1;
                            end
                            default: begin
                                op_q    <= dsp_op_e'(op_dsp);
                                counter <= '0;
                                state   <= RUN;
                            end
                        endcase
                    end
                end
                RUN: begin
                    counter <= counter + 1'b1;
                    if (counter == LAST_CNT) begin
                        state     <= DONE;
                        dsp_valid <= 1'b1;
                        if (op_q == DSP_MAC) begin
                            acc        <= add_wrap(acc, mul_product);
                            dsp_result <= add_wrap(acc, mul_product);
                        end else begin
                            dsp_result <= mul_product;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_op_controller.sv
// Directed bench for dsp_op_controller with a result scoreboard and latency/stall checks.
module tb_dsp_op_controller;
    import dsp_pkg::*;

    localparam int XLEN       = 32;
    localparam int MUL_CYCLES = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start_dsp = 1'b0;
    logic [1:0]      op_dsp = 2'b00;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            stall;
    logic            busy;
    logic [XLEN-1:0] dsp_result;
    logic            dsp_valid;

    int errors = 0;
    int checks = 0;
    logic [XLEN-1:0] sb_q[$];

    dsp_op_controller #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_dsp  (start_dsp),
        .op_dsp     (op_dsp),
        .op_a       (op_a),
        .op_b       (op_b),
        .stall      (stall),
        .busy       (busy),
        .dsp_result (dsp_result),
        .dsp_valid  (dsp_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request, holds start while stalled, and checks result, latency and stall length.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit mess);
        int lat;
        int stalls;
        int nvalid;
        int vcyc;
        bit drop;
        logic [31:0] want;
        lat = is_mul_op(op) ? MUL_CYCLES + 1 : 1;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        start_dsp = 1'b1;
        op_dsp    = op;
        op_a      = a;
        op_b      = b;
        stalls = 0;
        nvalid = 0;
        vcyc   = -1;
        for (int cyc = 0; cyc < lat + 3; cyc++) begin
            @(negedge clk);
            if (stall) stalls++;
            drop = !stall;
            if (dsp_valid) begin
                nvalid++;
                vcyc = cyc;
                if (sb_q.size() > 0) begin
                    want = sb_q.pop_front();
                    check({tag, " result"}, dsp_result, want);
                end
            end
            @(posedge clk); #1;
            if (mess) begin
                if (cyc + 1 < lat) begin
                    start_dsp = 1'($urandom_range(0, 1));
                    op_dsp    = 2'($urandom);
                    op_a      = $urandom;
                    op_b      = $urandom;
                end else if (cyc + 1 == lat) begin
                    start_dsp = 1'b1;
                    op_dsp    = 2'($urandom);
                end else begin
                    start_dsp = 1'b0;
                end
            end else if (drop) begin
                start_dsp = 1'b0;
            end
        end
        start_dsp = 1'b0;
        check({tag, " valid count"}, 32'(nvalid), 32'd1);
        check({tag, " valid cycle"}, 32'(vcyc), 32'(lat));
        check({tag, " stall cycles"}, 32'(stalls), (lat == 1) ? 32'd0 : 32'(lat));
        check({tag, " busy at end"}, {31'd0, busy}, 32'd0);
        check({tag, " scoreboard empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int nvalid;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start_dsp = 1'($urandom_range(0, 1));
            op_dsp    = 2'($urandom);
            op_a      = $urandom;
            op_b      = $urandom;
            @(negedge clk);
            check("reset stall", {31'd0, stall}, 32'd0);
            check("reset busy", {31'd0, busy}, 32'd0);
            check("reset valid", {31'd0, dsp_valid}, 32'd0);
            check("reset result", dsp_result, 32'd0);
        end
        @(posedge clk); #1;
        start_dsp = 1'b0;
        reset     = 1'b1;

        // MUL held through its stall, then acc still zero
        run_op("mul7x6", DSP_MUL, 32'd7, 32'd6, 32'd42, 1'b0);
        run_op("read0", DSP_READ, 32'd0, 32'd0, 32'd0, 1'b0);

        // Accumulate sequence
        run_op("clr", DSP_CLR, 32'd0, 32'd0, 32'd0, 1'b0);
        run_op("mac3x4", DSP_MAC, 32'd3, 32'd4, 32'd12, 1'b0);
        run_op("mac5x5", DSP_MAC, 32'd5, 32'd5, 32'd37, 1'b0);
        run_op("read37", DSP_READ, 32'd0, 32'd0, 32'd37, 1'b0);

        // Wrap-around behaviour
        run_op("clr2", DSP_CLR, 32'd0, 32'd0, 32'd0, 1'b0);
        run_op("mac2x1", DSP_MAC, 32'd2, 32'd1, 32'd2, 1'b0);
        run_op("macwrap", DSP_MAC, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        run_op("mulhi", DSP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);
        run_op("mulmax", DSP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("read1", DSP_READ, 32'd0, 32'd0, 32'd1, 1'b0);

        // Operand churn during RUN and a start pulse in DONE
        run_op("mul9x9", DSP_MUL, 32'd9, 32'd9, 32'd81, 1'b1);

        // Asynchronous reset in the middle of a MAC
        run_op("clr3", DSP_CLR, 32'd0, 32'd0, 32'd0, 1'b0);
        run_op("mac5x1", DSP_MAC, 32'd5, 32'd1, 32'd5, 1'b0);
        @(posedge clk); #1;
        start_dsp = 1'b1;
        op_dsp    = DSP_MAC;
        op_a      = 32'd4;
        op_b      = 32'd4;
        repeat (10) @(posedge clk);
        #2;
        check("midrun stall", {31'd0, stall}, 32'd1);
        check("midrun busy", {31'd0, busy}, 32'd1);
        #1;
        reset     = 1'b0;
        start_dsp = 1'b0;
        #1;
        check("async stall", {31'd0, stall}, 32'd0);
        check("async busy", {31'd0, busy}, 32'd0);
        check("async valid", {31'd0, dsp_valid}, 32'd0);
        check("async result", dsp_result, 32'd0);
        @(posedge clk); #1;
        reset  = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dsp_valid) nvalid++;
        end
        check("aborted valid count", 32'(nvalid), 32'd0);
        run_op("read_after_abort", DSP_READ, 32'd0, 32'd0, 32'd0, 1'b0);
        run_op("mul2x3", DSP_MUL, 32'd2, 32'd3, 32'd6, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
